// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard between ID issue and WB retire.
// Drives the ID stall request and flags protocol violations.
module reg_scoreboard #(
   parameter int NREG         = 32,
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic       id_fire,
   input  logic       id_rf_we,
   input  logic [4:0] id_rf_waddr,
   input  logic [4:0] id_rs1,
   input  logic       id_rs1_used,
   input  logic [4:0] id_rs2,
   input  logic       id_rs2_used,
   input  logic       wb_fire,
   input  logic       wb_rf_we,
   input  logic [4:0] wb_rf_waddr,
   output logic       data_harzard_occur,
   output logic [2:0] inflight_cnt,
   output logic       sb_error
);

   logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
   logic issue, retire, same_reg;
   logic ovf, unf, inc, dec;
   logic rs1_haz, rs2_haz;

   assign issue    = id_fire & id_rf_we & (id_rf_waddr != 5'd0);
   assign retire   = wb_fire & wb_rf_we & (wb_rf_waddr != 5'd0);
   assign same_reg = issue & retire & (id_rf_waddr == wb_rf_waddr);

   // Hazard looks only at registered counters: a WB retire releases ID one cycle later.
   assign rs1_haz = id_rs1_used & (id_rs1 != 5'd0) & (cnt[id_rs1] != '0);
   assign rs2_haz = id_rs2_used & (id_rs2 != 5'd0) & (cnt[id_rs2] != '0);
   assign data_harzard_occur = id_valid & (rs1_haz | rs2_haz);

   always_comb begin
      cnt_nxt = cnt;
      ovf     = 1'b0;
      unf     = 1'b0;
      inc     = 1'b0;
      dec     = 1'b0;
      // Issue and retire to the same register cancel; no saturation check needed.
      if (!same_reg) begin
         if (issue) begin
            if (cnt[id_rf_waddr] == CNT_W'(MAX_INFLIGHT)) ovf = 1'b1;
            else begin
               cnt_nxt[id_rf_waddr] = cnt[id_rf_waddr] + 1'b1;
               inc = 1'b1;
            end
         end
         if (retire) begin
            if (cnt[wb_rf_waddr] == '0) unf = 1'b1;
            else begin
               cnt_nxt[wb_rf_waddr] = cnt[wb_rf_waddr] - 1'b1;
               dec = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         inflight_cnt <= 3'd0;
         sb_error     <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (inc && !dec && inflight_cnt != 3'd7)      inflight_cnt <= inflight_cnt + 3'd1;
         else if (dec && !inc && inflight_cnt != 3'd0) inflight_cnt <= inflight_cnt - 3'd1;
         sb_error <= sb_error | ovf | unf | (id_fire & data_harzard_occur);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed + randomized bench for reg_scoreboard against a per-register pending-count model.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_fire, id_rf_we, id_rs1_used, id_rs2_used;
   logic [4:0] id_rf_waddr, id_rs1, id_rs2, wb_rf_waddr;
   logic       wb_fire, wb_rf_we;
   logic       data_harzard_occur, sb_error;
   logic [2:0] inflight_cnt;

   reg_scoreboard dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_fire(id_fire), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
      .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
      .wb_fire(wb_fire), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
      .data_harzard_occur(data_harzard_occur), .inflight_cnt(inflight_cnt), .sb_error(sb_error)
   );

   always #5 clk = ~clk;

   int   n_chk = 0, n_fail = 0;
   int   m_cnt [32];
   bit   m_err;
   logic haz_seen;
   int   q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_pending(input logic [4:0] r);
      return (r != 0) && (m_cnt[r] > 0);
   endfunction

   function automatic bit m_haz();
      return id_valid && ((id_rs1_used && m_pending(id_rs1)) || (id_rs2_used && m_pending(id_rs2)));
   endfunction

   function automatic int m_total();
      int s = 0;
      foreach (m_cnt[i]) s += m_cnt[i];
      return (s > 7) ? 7 : s;
   endfunction

   task automatic idle();
      id_valid = 0; id_fire = 0; id_rf_we = 0; id_rf_waddr = 0;
      id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
      wb_fire = 0; wb_rf_we = 0; wb_rf_waddr = 0;
   endtask

   task automatic issue(input logic [4:0] a);
      id_valid = 1; id_fire = 1; id_rf_we = 1; id_rf_waddr = a;
   endtask

   task automatic retire(input logic [4:0] a);
      wb_fire = 1; wb_rf_we = 1; wb_rf_waddr = a;
   endtask

   task automatic probe(input logic [4:0] a);
      id_valid = 1; id_rs1 = a; id_rs1_used = 1;
   endtask

   // One clock: check combinational stall before the edge, update model, check registered outputs after.
   task automatic tick();
      bit iss, ret, fire_haz;
      @(negedge clk);
      haz_seen = data_harzard_occur;
      fire_haz = id_fire && m_haz();
      if (!reset) chk("hazard", {31'd0, data_harzard_occur}, {31'd0, m_haz()});
      iss = id_fire && id_rf_we && id_rf_waddr != 0;
      ret = wb_fire && wb_rf_we && wb_rf_waddr != 0;
      @(posedge clk);
      if (reset) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_err = 0;
      end else begin
         if (fire_haz) m_err = 1;
         if (!(iss && ret && id_rf_waddr == wb_rf_waddr)) begin
            if (iss) begin
               if (m_cnt[id_rf_waddr] == 3) m_err = 1;
               else m_cnt[id_rf_waddr]++;
            end
            if (ret) begin
               if (m_cnt[wb_rf_waddr] == 0) m_err = 1;
               else m_cnt[wb_rf_waddr]--;
            end
         end
      end
      #1;
      chk("inflight_cnt", {29'd0, inflight_cnt}, m_total());
      chk("sb_error", {31'd0, sb_error}, {31'd0, m_err});
   endtask

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0;
      idle();

      // Reset with random inputs held
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         {id_valid, id_fire, id_rf_we, id_rs1_used, id_rs2_used, wb_fire, wb_rf_we} = 7'($urandom);
         id_rf_waddr = 5'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); wb_rf_waddr = 5'($urandom);
         tick();
      end
      reset = 0; idle(); probe(5'd3);
      tick();
      chk("rst_hazard", {31'd0, haz_seen}, 32'd0);
      chk("rst_inflight", {29'd0, inflight_cnt}, 32'd0);
      chk("rst_sb_error", {31'd0, sb_error}, 32'd0);

      // add.w r3 then dependent read: stall 3 cycles, retire in third, release after
      idle(); issue(5'd3); tick();
      idle(); probe(5'd3); tick(); chk("r3_stall_c1", {31'd0, haz_seen}, 32'd1);
      tick();                        chk("r3_stall_c2", {31'd0, haz_seen}, 32'd1);
      retire(5'd3); tick();          chk("r3_stall_c3", {31'd0, haz_seen}, 32'd1);
      idle(); probe(5'd3); id_fire = 1; tick();
      chk("r3_release", {31'd0, haz_seen}, 32'd0);
      chk("r3_inflight", {29'd0, inflight_cnt}, 32'd0);

      // Self-dependency: source equals own destination does not stall
      idle(); issue(5'd10); id_rs1 = 5'd10; id_rs1_used = 1; tick();
      chk("self_dep", {31'd0, haz_seen}, 32'd0);
      idle(); retire(5'd10); tick();

      // Three writes to r5 fill the counter, fourth overflows
      for (int i = 0; i < 3; i++) begin idle(); issue(5'd5); tick(); end
      chk("r5_inflight3", {29'd0, inflight_cnt}, 32'd3);
      idle(); issue(5'd5); tick();
      chk("r5_ovf_err", {31'd0, sb_error}, 32'd1);
      chk("r5_ovf_sat", {29'd0, inflight_cnt}, 32'd3);
      idle(); reset = 1; tick(); reset = 0;

      // Same-cycle issue/retire on r7, then split r8/r7
      idle(); issue(5'd7); tick();
      idle(); issue(5'd7); retire(5'd7); tick();
      chk("r7_same_inflight", {29'd0, inflight_cnt}, 32'd1);
      idle(); probe(5'd7); issue(5'd8); id_fire = 1; id_rs1_used = 0; retire(5'd7); tick();
      idle(); probe(5'd7); tick(); chk("r7_cleared", {31'd0, haz_seen}, 32'd0);
      idle(); probe(5'd8); tick(); chk("r8_pending", {31'd0, haz_seen}, 32'd1);
      chk("r8_inflight", {29'd0, inflight_cnt}, 32'd1);
      idle(); retire(5'd8); tick();

      // r0 is never tracked and never stalls
      idle(); issue(5'd0); tick();
      chk("r0_no_count", {29'd0, inflight_cnt}, 32'd0);
      idle(); id_valid = 1; id_rs1_used = 1; id_rs2_used = 1; tick();
      chk("r0_no_stall", {31'd0, haz_seen}, 32'd0);
      idle(); retire(5'd0); tick();
      chk("r0_retire_ok", {31'd0, sb_error}, 32'd0);

      // Underflow on r9, then reset clears the sticky flag
      idle(); retire(5'd9); tick();
      chk("r9_unf_err", {31'd0, sb_error}, 32'd1);
      idle(); tick();
      chk("sticky", {31'd0, sb_error}, 32'd1);
      reset = 1; tick(); reset = 0;
      chk("err_cleared", {31'd0, sb_error}, 32'd0);

      // Firing while stalled is flagged but the issue still counts
      idle(); issue(5'd4); tick();
      idle(); issue(5'd6); id_rs2 = 5'd4; id_rs2_used = 1; tick();
      chk("fire_stall_err", {31'd0, sb_error}, 32'd1);
      chk("fire_stall_cnt", {29'd0, inflight_cnt}, 32'd2);
      idle(); reset = 1; tick(); reset = 0;
      chk("rst_again", {31'd0, sb_error}, 32'd0);
      q.delete();

      // Random legal traffic: in-order retirement, at most three in flight
      for (int n = 0; n < 400; n++) begin
         idle();
         id_valid = 1'($urandom);
         id_rs1 = 5'($urandom); id_rs1_used = 1'($urandom);
         id_rs2 = 5'($urandom); id_rs2_used = 1'($urandom);
         id_rf_we = 1'($urandom); id_rf_waddr = 5'($urandom_range(0, 12));
         if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
            wb_fire = 1; wb_rf_waddr = 5'(q.pop_front()); wb_rf_we = 1;
         end else begin
            wb_fire = 1'($urandom); wb_rf_we = 0; wb_rf_waddr = 5'($urandom);
         end
         if (id_valid && !m_haz() && q.size() < 3 && $urandom_range(0, 1) == 1) begin
            id_fire = 1;
            q.push_back(id_rf_we ? int'(id_rf_waddr) : 0);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
